// File: rtl/uart_rx_if.sv
// Bundle of the serial pin, the parity configuration and the received-word outputs of uart_rx.
// The receiver attaches through the slave modport; the pin/system side uses master.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stop_Err;
    logic                  Busy;

    modport master (
        output RX_IN,
        output PAR_EN,
        output PAR_TYP,
        input  P_DATA,
        input  Data_Valid,
        input  Par_Err,
        input  Stop_Err,
        input  Busy
    );

    modport slave (
        input  RX_IN,
        input  PAR_EN,
        input  PAR_TYP,
        output P_DATA,
        output Data_Valid,
        output Par_Err,
        output Stop_Err,
        output Busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// CLK runs at PRESCALE x baud; each bit is the majority of three samples around mid-bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int EW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EW-1:0] SAMPLE_LO  = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] SAMPLE_MID = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] SAMPLE_HI  = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] EDGE_LAST  = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q,      state_d;
    logic [1:0]            rx_sync_q,    rx_sync_d;
    logic [EW-1:0]         edge_cnt_q,   edge_cnt_d;
    logic [BW-1:0]         bit_cnt_q,    bit_cnt_d;
    logic [1:0]            samp_q,       samp_d;
    logic [DATA_WIDTH-1:0] data_q,       data_d;
    logic                  par_en_q,     par_en_d;
    logic                  par_typ_q,    par_typ_d;
    logic                  par_ok_q,     par_ok_d;
    logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q,    par_err_d;
    logic                  stop_err_q,   stop_err_d;

    logic rx_s;
    logic majority;

    // Two-flop synchroniser; the pin idles high so the flops reset to 1 to avoid a false start.
    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_sync_d = {rx_sync_q[0], bus.RX_IN};
        // The third sample is the live synchronised line in the cycle the bit is decided.
        majority  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_ok_d     = par_ok_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stop_err_d   = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = (edge_cnt_q == EDGE_LAST) ? '0 : edge_cnt_q + EW'(1);
            if (edge_cnt_q == SAMPLE_LO) begin
                samp_d[0] = rx_s;
            end
            if (edge_cnt_q == SAMPLE_MID) begin
                samp_d[1] = rx_s;
            end
        end

        case (state_q)
            IDLE: begin
                // The cycle that first sees the low line is edge 0 of the start bit.
                if (!rx_s) begin
                    state_d    = START;
                    edge_cnt_d = EW'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = bus.PAR_EN;
                    par_typ_d  = bus.PAR_TYP;
                    par_ok_d   = 1'b1;
                end
            end

            START: begin
                if (edge_cnt_q == SAMPLE_HI && majority) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (edge_cnt_q == EDGE_LAST) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                // Shifting in from the top leaves the first (LSB) bit at position 0 after the last bit.
                if (edge_cnt_q == SAMPLE_HI) begin
                    data_d                 = data_q >> 1;
                    data_d[DATA_WIDTH-1]   = majority;
                end
                if (edge_cnt_q == EDGE_LAST) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end

            PARITY: begin
                if (edge_cnt_q == SAMPLE_HI) begin
                    par_ok_d = ~(^data_q ^ majority ^ par_typ_q);
                end
                if (edge_cnt_q == EDGE_LAST) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                // Deciding at mid stop bit leaves half a bit of margin for a back-to-back start edge.
                if (edge_cnt_q == SAMPLE_HI) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    if (!majority) begin
                        stop_err_d = 1'b1;
                    end else if (!par_ok_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = data_q;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
        if (RST) begin
            state_q      <= IDLE;
            rx_sync_q    <= 2'b11;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_ok_q     <= 1'b1;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_sync_q    <= rx_sync_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_ok_q     <= par_ok_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.Data_Valid = data_valid_q;
    assign bus.Par_Err    = par_err_q;
    assign bus.Stop_Err   = stop_err_q;
    assign bus.Busy       = (state_q != IDLE);
endmodule
